// File: rtl/countdown_timer_pkg.sv
// ============================================================================
// Module : countdown_timer_pkg
// Brief  : Shared state encoding and default sizes for countdown_timer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package countdown_timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int c_def_width = 3;
    localparam int c_def_evw   = 8;

endpackage : countdown_timer_pkg

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// Module : countdown_timer
// Brief  : One-shot/periodic down counter with registered expire pulse and a
//          wrapping expiration tally.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int EVW   = c_def_evw
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic [EVW-1:0]   exp_cnt
);

    state_t           r_state;
    state_t           w_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count;
    logic             r_busy;
    logic             r_expire;
    logic             w_expire;
    logic [EVW-1:0]   r_exp_cnt;

    // Priority: stop > start > auto_reload > decrement.
    always_comb begin
        w_state = r_state;
        w_count = r_count;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state = RUN;
                    w_count = load_val;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state = IDLE;
                end else if (start) begin
                    w_count = load_val;
                end else if (r_count != '0) begin
                    w_count = r_count - WIDTH'(1);
                end else if (auto_reload) begin
                    w_count = load_val;
                end else begin
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        w_expire = (w_state == RUN) && (w_count == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_expire  <= 1'b0;
            r_exp_cnt <= '0;
        end else begin
            r_state  <= w_state;
            r_count  <= w_count;
            r_busy   <= (w_state == RUN);
            r_expire <= w_expire;
            if (w_expire) begin
                r_exp_cnt <= r_exp_cnt + EVW'(1);
            end
        end
    end

    assign count   = r_count;
    assign busy    = r_busy;
    assign expire  = r_expire;
    assign exp_cnt = r_exp_cnt;

endmodule : countdown_timer

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module : tb_countdown_timer
// Brief  : Directed bench for countdown_timer with a per-cycle reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [2:0] load_val;
    logic [2:0] count;
    logic       busy;
    logic       expire;
    logic [7:0] exp_cnt;

    int checks = 0;
    int errors = 0;

    // Reference: a running flag, an integer count and an integer tally.
    bit m_running = 1'b0;
    int m_count   = 0;
    int m_exp     = 0;

    countdown_timer #(.WIDTH(3), .EVW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .count       (count),
        .busy        (busy),
        .expire      (expire),
        .exp_cnt     (exp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_running = 1'b0;
            m_count   = 0;
            m_exp     = 0;
        end else begin
            if (stop) begin
                m_running = 1'b0;
            end else if (start) begin
                m_running = 1'b1;
                m_count   = int'(load_val);
            end else if (m_running) begin
                if (m_count > 0)      m_count = m_count - 1;
                else if (auto_reload) m_count = int'(load_val);
                else                  m_running = 1'b0;
            end
            if (m_running && m_count == 0) m_exp = (m_exp + 1) % 256;
        end
    end

    always @(negedge clk) begin
        chk("model_count",   int'(count),   m_count);
        chk("model_busy",    int'(busy),    int'(m_running));
        chk("model_expire",  int'(expire),  int'(m_running && m_count == 0));
        chk("model_exp_cnt", int'(exp_cnt), m_exp);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; load_val = '0;
        #2;
        chk("reset_count",  int'(count),   0);
        chk("reset_busy",   int'(busy),    0);
        chk("reset_expire", int'(expire),  0);
        chk("reset_expcnt", int'(exp_cnt), 0);
        tick(2);
        rst = 1'b1;

        // One-shot, load 5
        load_val = 3'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("oneshot_load_count", int'(count), 5);
        chk("oneshot_load_busy",  int'(busy),  1);
        tick(5);
        chk("oneshot_zero_count",  int'(count),  0);
        chk("oneshot_zero_expire", int'(expire), 1);
        tick(1);
        chk("oneshot_end_busy",   int'(busy),    0);
        chk("oneshot_end_expire", int'(expire),  0);
        chk("oneshot_end_expcnt", int'(exp_cnt), 1);

        // Periodic, load 3: ten more expirations in 40 edges
        load_val = 3'd3; auto_reload = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(39);
        chk("periodic_expire", int'(expire),  1);
        chk("periodic_expcnt", int'(exp_cnt), 11);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_at_expire_busy",  int'(busy),   0);
        chk("stop_at_expire_count", int'(count),  0);
        chk("stop_at_expire_exp",   int'(expire), 0);

        // Stop at count 2
        auto_reload = 1'b0; load_val = 3'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("pre_stop_count", int'(count), 2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);
        chk("stop_hold_count", int'(count), 2);
        chk("stop_hold_busy",  int'(busy),  0);

        // start + stop together while idle
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy",  int'(busy),  0);
        chk("start_stop_count", int'(count), 2);

        // Restart at count 4 with new load 6
        load_val = 3'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        chk("pre_restart_count", int'(count), 4);
        load_val = 3'd6; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_count", int'(count), 6);

        // Reset mid-run, observed before the next clock edge
        load_val = 3'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        #1 rst = 1'b0;
        #1;
        chk("midrst_count",  int'(count),   0);
        chk("midrst_busy",   int'(busy),    0);
        chk("midrst_expire", int'(expire),  0);
        chk("midrst_expcnt", int'(exp_cnt), 0);
        tick(1);
        rst = 1'b1;

        // Zero load with auto reload: expire every cycle, tally wraps
        load_val = 3'd0; auto_reload = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("zero_count",  int'(count),   0);
        chk("zero_expire", int'(expire),  1);
        chk("zero_expcnt", int'(exp_cnt), 1);
        tick(1);
        chk("zero_expire2", int'(expire),  1);
        chk("zero_expcnt2", int'(exp_cnt), 2);
        tick(254);
        chk("wrap_expcnt", int'(exp_cnt), 0);
        chk("wrap_expire", int'(expire),  1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        auto_reload = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_countdown_timer

`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Programmable one-shot/periodic countdown timer that loads a start value, decrements once per clock, and emits a single-cycle `expire` pulse when it reaches zero. It is the control stage in front of the free-running down counter. It gives downstream logic a start/stop-able, reloadable count with an explicit terminal-count event, so consumers do not need to decode `count == 0` themselves. Expirations are tallied in a wrapping event counter for status readback.

## Interface
- `WIDTH`, 3: width of `load_val` and `count`.
- `EVW`, 8: width of the expiration event counter `exp_cnt`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each edge; loads `load_val` and enters RUN.
- `stop`  in  1  level sampled each edge; returns to IDLE, holding `count`.
- `auto_reload`  in  1  sampled only on the edge where `count` is 0 in RUN; 1 means reload and continue.
- `load_val`  in  WIDTH  start value, sampled only on start or reload.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  1 while in RUN, registered.
- `expire`  out  1  one-cycle pulse, high in the cycle `count` is 0 in RUN, registered.
- `exp_cnt`  out  EVW  number of expirations since reset, wraps at 2^EVW.

## Operation
- The FSM has two states: IDLE and RUN.
- Reset values: state=IDLE, `count`=0, `busy`=0, `expire`=0, `exp_cnt`=0.
- IDLE:
  - `count` holds.
  - `start`=1 (and `stop`=0) loads `count`=`load_val` and moves to RUN.
  - `stop` alone has no effect.
- RUN with `count`≠0:
  - `count` decrements by 1.
  - `start`=1 restarts: `count`=`load_val`, stays in RUN.
  - `stop`=1 moves to IDLE; `count` holds its current value.
- RUN with `count`=0 (the expire cycle):
  - `stop`=1 moves to IDLE with `count`=0.
  - Otherwise `start`=1 or `auto_reload`=1 loads `count`=`load_val` and stays in RUN.
  - Otherwise the FSM moves to IDLE with `count`=0.
- Priority for simultaneous inputs: `stop` > `start` > `auto_reload` > decrement.
- `expire` is registered: it is set on any edge whose next state is RUN with next `count`=0, and cleared otherwise.
- `exp_cnt` increments on every edge where the next value of `expire` is 1. It wraps from 2^EVW−1 to 0.
- `load_val`=0 on start: RUN with `count`=0 and `expire`=1 the next cycle. With `auto_reload`=1, `expire` stays high every cycle.
- No underflow: `count` never wraps below 0. The count width is exactly WIDTH.
- Reset asserted at any time forces all reset values immediately, regardless of clock.

## Timing
- Start latency: `start` high at edge N gives `count`=`load_val` and `busy`=1 after edge N.
- Expiry: `expire`=1 after edge N+`load_val`, for exactly one cycle, coincident with `count`=0.
- One-shot: after edge N+`load_val`+1, `busy`=0 and `expire`=0.
- Periodic mode: the `expire` period is `load_val`+1 cycles, with no gap cycle at reload.
- Stop latency: one edge. `busy` falls and `expire` clears after the edge that samples `stop`.
- Reset release: the first active edge after `rst` rises may sample `start`.

## Structure
- Package `countdown_timer_pkg` holds:
  - the state enum {IDLE, RUN};
  - the default WIDTH and EVW constants.
- Single module, no sub-module. The FSM, count register, expire flag and event counter share one next-state block.

## Test plan
- Reset mid-RUN: WIDTH=3, `load_val`=5, start, then drop `rst` after 2 cycles -> `count`=0, `busy`=0, `expire`=0, `exp_cnt`=0 immediately (before the next clock edge).
- One-shot: `load_val`=5, `start` pulse at edge 0 -> `count` 5,4,3,2,1,0, with `expire` high only with 0 (after edge 5); `busy` low after edge 6; `exp_cnt`=1.
- Periodic: `load_val`=3, `auto_reload`=1 -> `count` 3,2,1,0,3,2,1,0…; `expire` every 4 cycles; after 10 periods `exp_cnt`=10.
- Stop/start collisions:
  - `stop` at `count`=2 -> IDLE, `count` holds 2, no `expire`.
  - `start`+`stop` together -> stays IDLE.
  - `stop` in the expire cycle with `auto_reload`=1 -> IDLE, `count`=0.
- Restart and zero load: `start` at `count`=4 with `load_val`=6 -> `count`=6 next cycle. `load_val`=0 with `auto_reload`=1 -> `expire` continuously high, `exp_cnt` +1 per cycle.
- Wrap: EVW=8, force 256 expirations (`load_val`=0, `auto_reload`=1, 256 cycles) -> `exp_cnt` returns to 0.
